mem_stage_sram: RTL and testbench

MEM stage of the 5-stage MIPS pipeline. It sits directly after the EXE/MEM pipeline register and consumes its memory controls, ALU result (the address) and store value. It owns a word-addressed data memory with a fixed multi-cycle access latency. While an access is in flight it raises freeze, which holds the PC, the IF/ID, ID/EXE and EXE/MEM registers. Read data goes to the MEM/WB register.

---
 rtl/mips_mem_pkg.sv | 19 +
 rtl/data_mem_array.sv | 45 ++++
 rtl/mem_stage_sram.sv | 155 +++++++++++++++
 tb/tb_mem_stage_sram.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS MEM stage.
//   mem_state_e       : MEM access FSM state encoding (IDLE/WAIT/DONE)
//   ADDR_BASE_DEFAULT : byte address that maps to data-memory word 0
//   WORD_BYTES        : bytes per data word
//   word_t            : 32-bit data word
package mips_mem_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  localparam int ADDR_BASE_DEFAULT = 1024;
  localparam int WORD_BYTES        = 4;

endpackage

// File: rtl/data_mem_array.sv
// Data memory array: DEPTH x 32-bit words, synchronous write, registered read.
//   clk, rst : clock; async active-high reset (clears only the read register)
//   we       : write mem[idx] <= wdata on the clock edge
//   re       : capture mem[idx] (or zero when rd_zero) into rdata
//   rd_zero  : force the captured read value to zero
//   idx      : word index
//   wdata    : write data
//   rdata    : registered read data, holds between reads
module data_mem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic          rd_zero,
  input  logic [AW-1:0] idx,
  input  word_t         wdata,
  output word_t         rdata
);

  word_t mem [DEPTH];
  word_t rdata_q, rdata_d;

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = rd_zero ? '0 : mem[idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_stage_sram.sv
// MEM stage of the 5-stage MIPS pipeline with a multi-cycle data memory.
// A load/store seen in IDLE is latched, waits WAIT_CYCLES cycles, performs
// the access on the last wait edge and spends one DONE cycle with freeze low
// so the pipeline can advance.
//
// State table:
//   IDLE | no access in flight; sample request inputs
//   WAIT | access latched; count down wait states, access when cnt == 0
//   DONE | access complete, read_data valid, freeze low for one cycle
//
// Ports:
//   clk, rst    : clock; async active-high reset
//   mem_r_en    : load request
//   mem_w_en    : store request (wins over mem_r_en)
//   alu_result  : byte address
//   st_val      : store data
//   read_data   : registered load data
//   freeze      : combinational pipeline stall
//   addr_err    : out-of-range pulse in DONE (only with MEM_BOUNDS_CHECK_EN)
//
// Build option: define MEM_BOUNDS_CHECK_EN to suppress out-of-range writes,
// return 0 for out-of-range reads and add the addr_err output. Without it,
// addresses wrap modulo DEPTH.
module mem_stage_sram
  import mips_mem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int ADDR_BASE   = ADDR_BASE_DEFAULT,
  parameter int WAIT_CYCLES = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  mem_r_en,
  input  logic  mem_w_en,
  input  word_t alu_result,
  input  word_t st_val,
  output word_t read_data,
  output logic  freeze
`ifdef MEM_BOUNDS_CHECK_EN
  ,
  output logic  addr_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);
  localparam word_t BASE = word_t'(ADDR_BASE);

  mem_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  word_t         wdata_q, wdata_d;
  logic          is_wr_q, is_wr_d;

  word_t offset;
  logic  req;
  logic  access;
  logic  mem_we, mem_re, rd_zero;
  logic  unused_addr_bits;

  assign req    = mem_r_en | mem_w_en;
  assign offset = alu_result - BASE;
  // Byte-lane bits and index bits above AW do not select a word.
  assign unused_addr_bits = ^{offset[31:AW+2], offset[1:0]};
  assign access = (state_q == WAIT) && (cnt_q == '0);

`ifdef MEM_BOUNDS_CHECK_EN
  localparam word_t LIMIT = word_t'(ADDR_BASE + WORD_BYTES * DEPTH);
  logic oob_q, oob_d;
  logic addr_err_q, addr_err_d;

  assign mem_we  = access & is_wr_q & ~oob_q;
  assign rd_zero = oob_q;
  assign addr_err = addr_err_q;
`else
  assign mem_we  = access & is_wr_q;
  assign rd_zero = 1'b0;
`endif
  assign mem_re = access & ~is_wr_q;

  // Gated by rst so the stall releases immediately on reset even while
  // the request inputs are still asserted.
  assign freeze = req & (state_q != DONE) & ~rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
`ifdef MEM_BOUNDS_CHECK_EN
    oob_d      = oob_q;
    addr_err_d = access & oob_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = offset[AW+1:2];
          wdata_d = st_val;
          is_wr_d = mem_w_en;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
`ifdef MEM_BOUNDS_CHECK_EN
          oob_d   = (alu_result < BASE) || (alu_result >= LIMIT);
`endif
        end
      end
      WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
      oob_q      <= 1'b0;
      addr_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
`ifdef MEM_BOUNDS_CHECK_EN
      oob_q      <= oob_d;
      addr_err_q <= addr_err_d;
`endif
    end
  end

  data_mem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (mem_we),
    .re      (mem_re),
    .rd_zero (rd_zero),
    .idx     (idx_q),
    .wdata   (wdata_q),
    .rdata   (read_data)
  );

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed testbench for mem_stage_sram (DEPTH=64, ADDR_BASE=1024,
// WAIT_CYCLES=4). Each access holds its request through DONE, as the
// frozen EXE/MEM register would.
module tb_mem_stage_sram;
  import mips_mem_pkg::*;

  localparam int NCYC = 6;

  logic  clk = 1'b0;
  logic  clk_run = 1'b0;
  logic  rst = 1'b0;
  logic  mem_r_en = 1'b0;
  logic  mem_w_en = 1'b0;
  word_t alu_result = '0;
  word_t st_val = '0;
  word_t read_data;
  logic  freeze;
`ifdef MEM_BOUNDS_CHECK_EN
  logic  addr_err;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  mem_stage_sram #(
    .DEPTH       (64),
    .ADDR_BASE   (1024),
    .WAIT_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .alu_result (alu_result),
    .st_val     (st_val),
    .read_data  (read_data),
    .freeze     (freeze)
`ifdef MEM_BOUNDS_CHECK_EN
    ,
    .addr_err   (addr_err)
`endif
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  // Stimulus only: drive one access for NCYC cycles, recording freeze and
  // addr_err per cycle and read_data in the final (DONE) cycle.
  task automatic run_op(input logic w, input logic r, input word_t addr,
                        input word_t data, output logic [NCYC-1:0] frz,
                        output logic [NCYC-1:0] err, output word_t rd);
    mem_w_en = w; mem_r_en = r; alu_result = addr; st_val = data;
    frz = '0; err = '0; rd = '0;
    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      frz[i] = freeze;
`ifdef MEM_BOUNDS_CHECK_EN
      err[i] = addr_err;
`endif
      if (i == NCYC - 1) rd = read_data;
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_cycle();
    mem_w_en = 1'b0; mem_r_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    vec_cnt++;
    if (freeze !== 1'b0) begin err_cnt++; $display("FAIL reset_freeze got %b want 0", freeze); end
    vec_cnt++;
    if (read_data !== 32'h0) begin err_cnt++; $display("FAIL reset_read_data got %h want 0", read_data); end
    vec_cnt++;
    if (dut.state_q !== IDLE) begin err_cnt++; $display("FAIL reset_state got %0d want IDLE", dut.state_q); end
`ifdef MEM_BOUNDS_CHECK_EN
    vec_cnt++;
    if (addr_err !== 1'b0) begin err_cnt++; $display("FAIL reset_addr_err got %b want 0", addr_err); end
`endif
    clk_run = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_cycle();
  endtask

  task automatic test_store_load();
    logic [NCYC-1:0] frz, err;
    word_t rd;
    run_op(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, frz, err, rd);
    vec_cnt++;
    if (frz !== 6'b011111) begin err_cnt++; $display("FAIL store_freeze got %b want 011111", frz); end
    vec_cnt++;
    if (rd !== 32'h0) begin err_cnt++; $display("FAIL store_read_data got %h want 0", rd); end
    idle_cycle();
    run_op(1'b0, 1'b1, 32'd1028, 32'h0, frz, err, rd);
    vec_cnt++;
    if (frz !== 6'b011111) begin err_cnt++; $display("FAIL load_freeze got %b want 011111", frz); end
    vec_cnt++;
    if (rd !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL load_1028 got %h want deadbeef", rd); end
    idle_cycle();
  endtask

  task automatic test_both_enables();
    logic [NCYC-1:0] frz, err;
    word_t rd;
    run_op(1'b1, 1'b1, 32'd1032, 32'h12345678, frz, err, rd);
    vec_cnt++;
    if (rd !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL both_en_read_data got %h want deadbeef", rd); end
    idle_cycle();
    run_op(1'b0, 1'b1, 32'd1032, 32'h0, frz, err, rd);
    vec_cnt++;
    if (rd !== 32'h12345678) begin err_cnt++; $display("FAIL both_en_load_1032 got %h want 12345678", rd); end
    idle_cycle();
  endtask

  task automatic test_reset_mid_write();
    logic [NCYC-1:0] frz, err;
    word_t rd;
    run_op(1'b1, 1'b0, 32'd1036, 32'h00001111, frz, err, rd);
    idle_cycle();
    mem_w_en = 1'b1; mem_r_en = 1'b0; alu_result = 32'd1036; st_val = 32'h55;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    vec_cnt++;
    if (freeze !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_freeze got %b want 0", freeze); end
    vec_cnt++;
    if (read_data !== 32'h0) begin err_cnt++; $display("FAIL rst_mid_read_data got %h want 0", read_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycle();
    run_op(1'b0, 1'b1, 32'd1036, 32'h0, frz, err, rd);
    vec_cnt++;
    if (rd !== 32'h00001111) begin err_cnt++; $display("FAIL rst_mid_load_1036 got %h want 00001111", rd); end
    idle_cycle();
  endtask

  task automatic test_wrap();
    logic [NCYC-1:0] frz, err;
    word_t rd;
    run_op(1'b1, 1'b0, 32'd1024, 32'h77, frz, err, rd);
    idle_cycle();
    run_op(1'b1, 1'b0, 32'd1280, 32'hA, frz, err, rd);
    vec_cnt++;
    if (frz !== 6'b011111) begin err_cnt++; $display("FAIL wrap_store_freeze got %b want 011111", frz); end
`ifdef MEM_BOUNDS_CHECK_EN
    vec_cnt++;
    if (err !== 6'b100000) begin err_cnt++; $display("FAIL oob_addr_err got %b want 100000", err); end
    idle_cycle();
    run_op(1'b0, 1'b1, 32'd1024, 32'h0, frz, err, rd);
    vec_cnt++;
    if (rd !== 32'h77) begin err_cnt++; $display("FAIL oob_word0 got %h want 77", rd); end
    vec_cnt++;
    if (err !== 6'b000000) begin err_cnt++; $display("FAIL inrange_addr_err got %b want 000000", err); end
    idle_cycle();
    run_op(1'b0, 1'b1, 32'd1280, 32'h0, frz, err, rd);
    vec_cnt++;
    if (rd !== 32'h0) begin err_cnt++; $display("FAIL oob_load_1280 got %h want 0", rd); end
`else
    idle_cycle();
    run_op(1'b0, 1'b1, 32'd1024, 32'h0, frz, err, rd);
    vec_cnt++;
    if (rd !== 32'hA) begin err_cnt++; $display("FAIL wrap_load_1024 got %h want a", rd); end
`endif
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    logic [NCYC-1:0] frz0, frz1, err;
    word_t rd0, rd1;
    run_op(1'b1, 1'b0, 32'd1040, 32'h100, frz0, err, rd0);
    idle_cycle();
    run_op(1'b1, 1'b0, 32'd1044, 32'h200, frz0, err, rd0);
    idle_cycle();
    run_op(1'b0, 1'b1, 32'd1040, 32'h0, frz0, err, rd0);
    run_op(1'b0, 1'b1, 32'd1044, 32'h0, frz1, err, rd1);
    vec_cnt++;
    if ({frz1, frz0} !== 12'b011111011111) begin
      err_cnt++; $display("FAIL b2b_freeze got %b want 011111011111", {frz1, frz0});
    end
    vec_cnt++;
    if (rd0 !== 32'h100) begin err_cnt++; $display("FAIL b2b_load0 got %h want 100", rd0); end
    vec_cnt++;
    if (rd1 !== 32'h200) begin err_cnt++; $display("FAIL b2b_load1 got %h want 200", rd1); end
    idle_cycle();
  endtask

  task automatic test_idle_hold();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (freeze !== 1'b0) begin err_cnt++; $display("FAIL idle_freeze[%0d] got %b want 0", i, freeze); end
      vec_cnt++;
      if (read_data !== 32'h200) begin err_cnt++; $display("FAIL idle_hold[%0d] got %h want 200", i, read_data); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_both_enables();
    test_reset_mid_write();
    test_wrap();
    test_back_to_back();
    test_idle_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
